// File: rtl/ctrl_pipe_seq.sv
// ctrl_pipe_seq: ID/EX, EX/MEM, MEM/WB control pipeline with load-use stall and branch squash; optional macro CTRL_SANITIZE_EN
module ctrl_pipe_seq #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_j,
    input  logic [1:0]        id_wb,
    input  logic [2:0]        id_m,
    input  logic [4:0]        id_ex,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              mem_zero,
    output logic [4:0]        ex_ex,
    output logic              ex_valid,
    output logic [2:0]        mem_m,
    output logic [REG_AW-1:0] mem_dst,
    output logic              mem_regwrite,
    output logic [1:0]        wb_wb,
    output logic [REG_AW-1:0] wb_dst,
    output logic              wb_regwrite,
    output logic              hold_if,
    output logic              jump_req,
    output logic              branch_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    logic [1:0]        ex_wb, mem_wb;
    logic [2:0]        ex_m;
    logic [REG_AW-1:0] ex_dst;
    logic              mem_valid, wb_valid, rst_q, live, load_use;
    logic              cap_j;
    logic [1:0]        cap_wb;
    logic [2:0]        cap_m;
    logic [4:0]        cap_ex;
`ifdef CTRL_SANITIZE_EN
    // only a solid 1 counts as set, so X/Z from don't-care decoder bits is stored as 0
    always_comb begin
        cap_j = (id_j === 1'b1);
        for (int i = 0; i < 2; i++) cap_wb[i] = (id_wb[i] === 1'b1);
        for (int i = 0; i < 3; i++) cap_m[i] = (id_m[i] === 1'b1);
        for (int i = 0; i < 5; i++) cap_ex[i] = (id_ex[i] === 1'b1);
    end
`else
    // decoder bits are taken verbatim
    always_comb begin
        cap_j  = id_j;
        cap_wb = id_wb;
        cap_m  = id_m;
        cap_ex = id_ex;
    end
`endif
    // outputs stay quiet during reset and the first cycle after release
    assign live         = ~rst & ~rst_q;
    assign load_use     = ex_valid & (ex_wb == 2'b01) & (ex_dst != '0) &
                          ((ex_dst == id_rs) | (ex_dst == id_rt)) & id_valid;
    assign hold_if      = live & load_use;
    assign branch_flush = live & mem_valid & mem_m[0] & mem_zero;
    assign jump_req     = live & id_valid & cap_j & ~hold_if & ~branch_flush;
    assign mem_regwrite = mem_valid & mem_wb[0];
    assign wb_regwrite  = wb_valid & wb_wb[0];
    // stage registers advance with priority reset > branch squash > load-use bubble > normal
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q     <= 1'b1;
            ex_wb     <= '0;
            ex_m      <= '0;
            ex_ex     <= '0;
            ex_dst    <= '0;
            ex_valid  <= 1'b0;
            mem_wb    <= '0;
            mem_m     <= '0;
            mem_dst   <= '0;
            mem_valid <= 1'b0;
            wb_wb     <= '0;
            wb_dst    <= '0;
            wb_valid  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            rst_q    <= 1'b0;
            wb_wb    <= mem_wb;
            wb_dst   <= mem_dst;
            wb_valid <= mem_valid;
            if (branch_flush) begin
                ex_wb     <= '0;
                ex_m      <= '0;
                ex_ex     <= '0;
                ex_dst    <= '0;
                ex_valid  <= 1'b0;
                mem_wb    <= '0;
                mem_m     <= '0;
                mem_dst   <= '0;
                mem_valid <= 1'b0;
                if (~&flush_cnt) flush_cnt <= flush_cnt + CNT_W'(1);
            end else begin
                mem_wb    <= ex_wb;
                mem_m     <= ex_m;
                mem_dst   <= ex_dst;
                mem_valid <= ex_valid;
                if (hold_if) begin
                    ex_wb    <= '0;
                    ex_m     <= '0;
                    ex_ex    <= '0;
                    ex_dst   <= '0;
                    ex_valid <= 1'b0;
                    if (~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
                end else begin
                    ex_wb    <= id_valid ? cap_wb : '0;
                    ex_m     <= id_valid ? cap_m : '0;
                    ex_ex    <= id_valid ? cap_ex : '0;
                    ex_dst   <= id_valid ? (cap_ex[0] ? id_rd : id_rt) : '0;
                    ex_valid <= id_valid;
                end
            end
        end
    end
endmodule

// File: tb/tb_ctrl_pipe_seq.sv
// tb_ctrl_pipe_seq: directed stimulus with queued expectations checked by an output monitor
module tb_ctrl_pipe_seq;
    logic        clk, rst, id_valid, id_j, mem_zero;
    logic [1:0]  id_wb;
    logic [2:0]  id_m;
    logic [4:0]  id_ex;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [4:0]  ex_ex;
    logic        ex_valid, mem_regwrite, wb_regwrite, hold_if, jump_req, branch_flush;
    logic [2:0]  mem_m;
    logic [4:0]  mem_dst, wb_dst;
    logic [1:0]  wb_wb;
    logic [15:0] stall_cnt, flush_cnt;
    int          tests = 0;
    int          fails = 0;
    logic [4:0]  q_ex[$];
    logic [4:0]  q_wb[$];

    ctrl_pipe_seq dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_j(id_j), .id_wb(id_wb), .id_m(id_m),
        .id_ex(id_ex), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
        .ex_ex(ex_ex), .ex_valid(ex_valid), .mem_m(mem_m), .mem_dst(mem_dst),
        .mem_regwrite(mem_regwrite), .wb_wb(wb_wb), .wb_dst(wb_dst), .wb_regwrite(wb_regwrite),
        .hold_if(hold_if), .jump_req(jump_req), .branch_flush(branch_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic j, input logic [1:0] wb, input logic [2:0] m,
                         input logic [4:0] ex, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid = v;
        id_j     = j;
        id_wb    = wb;
        id_m     = m;
        id_ex    = ex;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 3'b000, 5'b00000, 5'd0, 5'd0, 5'd0);
    endtask

    function automatic logic [63:0] all_out();
        return {6'b0, ex_ex, ex_valid, mem_m, mem_dst, mem_regwrite, wb_wb, wb_dst, wb_regwrite,
                hold_if, jump_req, branch_flush, stall_cnt, flush_cnt};
    endfunction

    // monitor: every valid EX bundle and every WB register write must match the next queued expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (ex_valid) begin
                if (q_ex.size() == 0) chk("ex_unexpected", 64'(ex_ex), 64'hdead);
                else chk("ex_ex", 64'(ex_ex), 64'(q_ex.pop_front()));
            end
            if (wb_regwrite) begin
                if (q_wb.size() == 0) chk("wb_unexpected", 64'(wb_dst), 64'hdead);
                else chk("wb_dst", 64'(wb_dst), 64'(q_wb.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1;
        mem_zero = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 3'b000, 5'b00000, 5'd0, 5'd0, 5'd0);
        tick();
        @(negedge clk);
        chk("reset_outputs", all_out(), 64'h0);
        tick();
        rst = 1'b0;
        q_ex.push_back(5'b00000);
        @(negedge clk);
        chk("post_release_outputs", all_out(), 64'h0);
        tick();
        idle();
        tick();
        // R-type through the pipe
        drive(1'b1, 1'b0, 2'b11, 3'b000, 5'b10101, 5'd1, 5'd2, 5'd3);
        q_ex.push_back(5'b10101);
        q_wb.push_back(5'd3);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("rtype_mem_dst", 64'(mem_dst), 64'd3);
        chk("rtype_mem_rw", 64'(mem_regwrite), 64'd1);
        tick();
        @(negedge clk);
        chk("rtype_wb_rw", 64'(wb_regwrite), 64'd1);
        chk("rtype_wb_wb", 64'(wb_wb), 64'd3);
        tick();
        tick();
        // load-use stall
        drive(1'b1, 1'b0, 2'b01, 3'b010, 5'b10000, 5'd1, 5'd4, 5'd9);
        q_ex.push_back(5'b10000);
        q_wb.push_back(5'd4);
        tick();
        drive(1'b1, 1'b0, 2'b11, 3'b000, 5'b00101, 5'd4, 5'd5, 5'd6);
        q_ex.push_back(5'b00101);
        q_wb.push_back(5'd6);
        @(negedge clk);
        chk("lu_hold", 64'(hold_if), 64'd1);
        tick();
        @(negedge clk);
        chk("lu_hold_released", 64'(hold_if), 64'd0);
        chk("lu_bubble", 64'(ex_valid), 64'd0);
        chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
        tick();
        idle();
        repeat (4) tick();
        // load to r0 never stalls
        drive(1'b1, 1'b0, 2'b01, 3'b010, 5'b10000, 5'd1, 5'd0, 5'd9);
        q_ex.push_back(5'b10000);
        q_wb.push_back(5'd0);
        tick();
        drive(1'b1, 1'b0, 2'b11, 3'b000, 5'b00101, 5'd0, 5'd7, 5'd8);
        q_ex.push_back(5'b00101);
        q_wb.push_back(5'd8);
        @(negedge clk);
        chk("r0_no_hold", 64'(hold_if), 64'd0);
        tick();
        idle();
        repeat (4) tick();
        chk("r0_stall_cnt", 64'(stall_cnt), 64'd1);
        // taken branch squashes the two younger bundles
        drive(1'b1, 1'b0, 2'b00, 3'b001, 5'b00010, 5'd1, 5'd2, 5'd0);
        q_ex.push_back(5'b00010);
        tick();
        drive(1'b1, 1'b0, 2'b11, 3'b000, 5'b00101, 5'd1, 5'd2, 5'd10);
        q_ex.push_back(5'b00101);
        tick();
        drive(1'b1, 1'b0, 2'b11, 3'b000, 5'b00101, 5'd1, 5'd2, 5'd11);
        mem_zero = 1'b1;
        @(negedge clk);
        chk("br_flush", 64'(branch_flush), 64'd1);
        tick();
        idle();
        mem_zero = 1'b0;
        @(negedge clk);
        chk("br_ex_valid", 64'(ex_valid), 64'd0);
        chk("br_mem_m", 64'(mem_m), 64'd0);
        chk("br_flush_cnt", 64'(flush_cnt), 64'd1);
        repeat (4) tick();
        // not-taken branch lets the follower through
        drive(1'b1, 1'b0, 2'b00, 3'b001, 5'b00010, 5'd1, 5'd2, 5'd0);
        q_ex.push_back(5'b00010);
        tick();
        drive(1'b1, 1'b0, 2'b11, 3'b000, 5'b00101, 5'd1, 5'd2, 5'd10);
        q_ex.push_back(5'b00101);
        q_wb.push_back(5'd10);
        tick();
        idle();
        @(negedge clk);
        chk("br_nt_flush", 64'(branch_flush), 64'd0);
        repeat (4) tick();
        chk("br_nt_flush_cnt", 64'(flush_cnt), 64'd1);
        // jump
        drive(1'b1, 1'b1, 2'b00, 3'b000, 5'b00000, 5'd0, 5'd0, 5'd0);
        q_ex.push_back(5'b00000);
        @(negedge clk);
        chk("j_req", 64'(jump_req), 64'd1);
        tick();
        idle();
        repeat (3) tick();
        // jump held back by a load-use stall
        drive(1'b1, 1'b0, 2'b01, 3'b010, 5'b10000, 5'd1, 5'd4, 5'd9);
        q_ex.push_back(5'b10000);
        q_wb.push_back(5'd4);
        tick();
        drive(1'b1, 1'b1, 2'b00, 3'b000, 5'b00000, 5'd4, 5'd0, 5'd0);
        q_ex.push_back(5'b00000);
        @(negedge clk);
        chk("j_stall_hold", 64'(hold_if), 64'd1);
        chk("j_stall_req", 64'(jump_req), 64'd0);
        tick();
        @(negedge clk);
        chk("j_after_req", 64'(jump_req), 64'd1);
        tick();
        idle();
        repeat (4) tick();
        chk("j_stall_cnt", 64'(stall_cnt), 64'd2);
        // reset while a load sits in MEM
        drive(1'b1, 1'b0, 2'b01, 3'b010, 5'b10000, 5'd1, 5'd5, 5'd9);
        q_ex.push_back(5'b10000);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("rst_load_in_mem", 64'({mem_regwrite, mem_dst}), 64'({1'b1, 5'd5}));
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b1, 2'b00, 3'b000, 5'b00000, 5'd0, 5'd0, 5'd0);
        tick();
        @(negedge clk);
        chk("rst_mid_outputs", all_out(), 64'h0);
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_mid_release", all_out(), 64'h0);
        repeat (2) tick();
`ifdef CTRL_SANITIZE_EN
        drive(1'b1, 1'b0, 2'bxx, 3'b001, 5'b00010, 5'd1, 5'd2, 5'd0);
        q_ex.push_back(5'b00010);
        tick();
        idle();
        repeat (2) tick();
        @(negedge clk);
        chk("san_wb_wb", 64'(wb_wb), 64'd0);
        repeat (2) tick();
`endif
        chk("q_ex_drained", 64'(q_ex.size()), 64'd0);
        chk("q_wb_drained", 64'(q_wb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
